// File: rtl/rsa_exp_ctrl.sv
// Left-to-right square-and-multiply sequencer for the RSA modexp datapath.
// Drives the shared modular multiplier and the accumulator load/init strobes.
module rsa_exp_ctrl #(
  parameter  int unsigned n    = 6,
  localparam int unsigned IDXW = $clog2(n)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [n-1:0]    exp_in,
  input  logic            mul_done,
  output logic            busy,
  output logic            acc_init,
  output logic            mul_start,
  output logic            mul_op,
  output logic            acc_load,
  output logic [IDXW-1:0] bit_idx,
  output logic            done
);

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    INIT     = 4'd1,
    SQ       = 4'd2,
    WAIT_SQ  = 4'd3,
    LD_SQ    = 4'd4,
    MUL      = 4'd5,
    WAIT_MUL = 4'd6,
    LD_MUL   = 4'd7,
    FIN      = 4'd8
  } state_t;

  state_t          state_q, state_d;
  logic [n-1:0]    exp_reg, exp_d;
  logic [IDXW-1:0] idx_d;
  logic            op_d;

  // Next-state, exponent capture and bit-index walk.
  always_comb begin
    state_d = state_q;
    exp_d   = exp_reg;
    idx_d   = bit_idx;
    op_d    = mul_op;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          exp_d   = exp_in;
          idx_d   = IDXW'(n - 1);
          state_d = INIT;
        end
      end
      INIT:     state_d = (exp_reg == '0) ? FIN : SQ;
      SQ:       state_d = WAIT_SQ;
      WAIT_SQ:  if (mul_done) state_d = LD_SQ;
      LD_SQ: begin
        if (exp_reg[bit_idx]) begin
          state_d = MUL;
        end else if (bit_idx == '0) begin
          state_d = FIN;
        end else begin
          idx_d   = bit_idx - IDXW'(1);
          state_d = SQ;
        end
      end
      MUL:      state_d = WAIT_MUL;
      WAIT_MUL: if (mul_done) state_d = LD_MUL;
      LD_MUL: begin
        if (bit_idx == '0) begin
          state_d = FIN;
        end else begin
          idx_d   = bit_idx - IDXW'(1);
          state_d = SQ;
        end
      end
      FIN:      state_d = IDLE;
      default:  state_d = IDLE;
    endcase
    // Operation select is latched on launch and held through the wait.
    if (state_d == SQ)  op_d = 1'b0;
    if (state_d == MUL) op_d = 1'b1;
  end

  // State register; strobes are registered decodes of the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      exp_reg   <= '0;
      bit_idx   <= '0;
      mul_op    <= 1'b0;
      busy      <= 1'b0;
      acc_init  <= 1'b0;
      mul_start <= 1'b0;
      acc_load  <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_q   <= state_d;
      exp_reg   <= exp_d;
      bit_idx   <= idx_d;
      mul_op    <= op_d;
      busy      <= (state_d != IDLE);
      acc_init  <= (state_d == INIT);
      mul_start <= (state_d == SQ) || (state_d == MUL);
      acc_load  <= (state_d == LD_SQ) || (state_d == LD_MUL);
      done      <= (state_d == FIN);
    end
  end

endmodule

// File: tb/tb_rsa_exp_ctrl.sv
// Scoreboard bench for rsa_exp_ctrl: behavioural multiplier/accumulator
// checks command order, bit index, run length and the final modexp result.
module tb_rsa_exp_ctrl;
  localparam int unsigned N    = 6;
  localparam int unsigned IDXW = $clog2(N);
  localparam int          TMO  = 3000;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [N-1:0]    exp_in;
  logic            mul_done;
  logic            busy, acc_init, mul_start, mul_op, acc_load, done;
  logic [IDXW-1:0] bit_idx;

  rsa_exp_ctrl #(.n(N)) dut (
    .clk(clk), .rst(rst), .start(start), .exp_in(exp_in), .mul_done(mul_done),
    .busy(busy), .acc_init(acc_init), .mul_start(mul_start), .mul_op(mul_op),
    .acc_load(acc_load), .bit_idx(bit_idx), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct { bit op; int idx; } op_t;
  typedef struct { int busy_cyc; longint result; int n_ops; } run_t;

  op_t    ops_q[$];
  run_t   run_q[$];
  int     vectors = 0;
  int     miscompares = 0;

  // Environment settings (only changed while the DUT is idle).
  int     lat = 1;
  longint base_v = 3, mod_v = 7;
  bit     inj_now = 1'b0, inj_sq = 1'b0;

  // Monitor / multiplier / accumulator model state.
  longint acc = 1, prod = 0;
  int     cnt = 0, busy_cnt = 0, init_cnt = 0, load_cnt = 0, start_cnt = 0;
  bit     pend_op = 1'b0, post_rst = 1'b0;
  op_t    mo;
  run_t   mr;

  function automatic void chk(input string name, input longint act, input longint req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endfunction

  // Expected command stream and run summary from the exponent's bits.
  task automatic issue(input logic [N-1:0] e, input longint b, input longint m, input int l);
    run_t r;
    int k = 0;
    longint res = 1;
    base_v = b; mod_v = m; lat = l;
    if (e != '0) begin
      for (int i = N - 1; i >= 0; i--) begin
        ops_q.push_back('{1'b0, i}); k++;
        if (e[i]) begin ops_q.push_back('{1'b1, i}); k++; end
      end
    end
    for (int j = 0; j < int'(e); j++) res = (res * b) % m;
    r.busy_cyc = 2 + k * (l + 2);
    r.result   = res;
    r.n_ops    = k;
    run_q.push_back(r);
    @(posedge clk); #1 start = 1'b1; exp_in = e;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_runs(input int left);
    int t = 0;
    while (run_q.size() > left && t < TMO) begin @(posedge clk); t++; end
    if (t >= TMO) begin
      vectors++; miscompares++;
      $display("FAIL run_timeout: %0d runs outstanding, expected %0d", run_q.size(), left);
      run_q.delete(); ops_q.delete();
    end
  endtask

  // Monitor: multiplier responder, accumulator model and scoreboard checks.
  always @(negedge clk) begin
    if (rst) begin
      ops_q.delete(); run_q.delete();
      cnt = 0; mul_done = 1'b0; busy_cnt = 0; init_cnt = 0; load_cnt = 0;
      start_cnt = 0; post_rst = 1'b1;
    end else begin
      if (post_rst) begin
        chk("post_reset_outputs", {busy, acc_init, mul_start, mul_op, acc_load, done, bit_idx}, 0);
        post_rst = 1'b0;
      end
      if (busy) busy_cnt++;
      if (acc_init) begin acc = 1; init_cnt++; end
      if (acc_load) begin acc = prod; load_cnt++; end
      mul_done = 1'b0;
      if (cnt > 0) begin
        chk("mul_op_stable", mul_op, pend_op);
        cnt--;
        if (cnt == 0) mul_done = 1'b1;
      end
      if (mul_start) begin
        start_cnt++;
        if (ops_q.size() == 0) begin
          chk("unexpected_mul_start", mul_start, 0);
        end else begin
          mo = ops_q.pop_front();
          chk("mul_op", mul_op, mo.op);
          chk("bit_idx", bit_idx, mo.idx);
        end
        pend_op = mul_op;
        prod = mul_op ? (acc * base_v) % mod_v : (acc * acc) % mod_v;
        cnt = lat;
        if (inj_sq) begin mul_done = 1'b1; inj_sq = 1'b0; end
      end
      if (inj_now) begin mul_done = 1'b1; inj_now = 1'b0; end
      if (done) begin
        if (run_q.size() == 0) begin
          chk("unexpected_done", done, 0);
        end else begin
          mr = run_q.pop_front();
          chk("done_while_busy", busy, 1);
          chk("busy_cycles", busy_cnt, mr.busy_cyc);
          chk("result", acc, mr.result);
          chk("acc_init_count", init_cnt, 1);
          chk("acc_load_count", load_cnt, mr.n_ops);
          chk("mul_start_count", start_cnt, mr.n_ops);
        end
        busy_cnt = 0; init_cnt = 0; load_cnt = 0; start_cnt = 0;
      end else if (run_q.size() == 0) begin
        chk("idle_quiet", {busy, acc_init, mul_start, acc_load}, 0);
      end
    end
  end

  initial begin
    logic [N-1:0] e;
    longint m, b;
    int t;
    rst = 1'b1; start = 1'b0; exp_in = '0; mul_done = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);

    // Directed: mixed bits, zero exponent, all ones with long latency.
    issue(6'b000101, 5, 97, 1);   wait_runs(0);
    issue(6'b000000, 9, 101, 1);  wait_runs(0);
    issue(6'b111111, 7, 1009, 4); wait_runs(0);

    // Re-pulsed start and changing exp_in mid-run are ignored.
    issue(6'b101101, 11, 257, 2);
    repeat (10) @(posedge clk);
    #1 start = 1'b1; exp_in = 6'b010010;
    @(posedge clk); #1 start = 1'b0; exp_in = 6'b111000;
    wait_runs(0);

    // Spurious mul_done in IDLE, then during SQ.
    lat = 2;
    @(posedge clk); #1 inj_now = 1'b1;
    repeat (3) @(posedge clk);
    #1 inj_sq = 1'b1;
    issue(6'b100000, 6, 53, 2); wait_runs(0);

    // start held high: second run begins right after FIN.
    begin
      run_t r;
      int k;
      longint res;
      e = 6'b010011; base_v = 4; mod_v = 61; lat = 1;
      k = 0; res = 1;
      for (int i = N - 1; i >= 0; i--) begin
        ops_q.push_back('{1'b0, i}); k++;
        if (e[i]) begin ops_q.push_back('{1'b1, i}); k++; end
      end
      for (int j = 0; j < int'(e); j++) res = (res * base_v) % mod_v;
      r.busy_cyc = 2 + k * 3; r.result = res; r.n_ops = k;
      for (int i = N - 1; i >= 0; i--) begin
        ops_q.push_back('{1'b0, i});
        if (e[i]) ops_q.push_back('{1'b1, i});
      end
      run_q.push_back(r); run_q.push_back(r);
      @(posedge clk); #1 start = 1'b1; exp_in = e;
      wait_runs(1);
      @(posedge clk); #1 start = 1'b0;
      wait_runs(0);
    end
    repeat (2) @(posedge clk);

    // Reset in WAIT_MUL, then a late mul_done must not cause a load.
    issue(6'b111111, 3, 211, 4);
    t = 0;
    do begin @(negedge clk); t++; end
    while (!(busy && mul_op && !mul_start) && t < TMO);
    if (t >= TMO) begin
      vectors++; miscompares++;
      $display("FAIL wait_mul_timeout: never reached multiply wait");
    end
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk);
    @(posedge clk); #1 inj_now = 1'b1;
    repeat (5) @(posedge clk);

    // Randomized runs.
    for (int it = 0; it < 20; it++) begin
      e = N'($urandom_range(0, 63));
      m = longint'($urandom_range(2, 5000));
      b = longint'($urandom_range(0, 32'(m - 1)));
      issue(e, b, m, int'($urandom_range(1, 4)));
      wait_runs(0);
      repeat (int'($urandom_range(1, 3))) @(posedge clk);
    end

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
